// File: rtl/hub75_pkg.sv
// rtl/hub75_pkg.sv - shared types and geometry for the HUB75 panel receiver
package hub75_pkg;

    localparam int PANEL_COLS    = 32;
    localparam int DEF_ROW_BITS  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DUMP = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // {rgb2, rgb1} as shifted in on one sclk edge
    typedef logic [5:0] pix_t;

    function automatic int cols_for(input int num_panels);
        return PANEL_COLS * num_panels;
    endfunction

endpackage

// File: rtl/hub75_in_sync.sv
// rtl/hub75_in_sync.sv - two-flop input synchronizer with optional edge detect
module hub75_in_sync #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter bit               EDGES   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o,
    output logic             rise_o,
    output logic             fall_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two-stage capture; reset value matches the driver's idle level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

    generate
        if (EDGES) begin : g_edge
            logic prev_q;

            // Previous synced level of bit 0 for edge detection
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    prev_q <= RST_VAL[0];
                end else begin
                    prev_q <= sync_q[0];
                end
            end

            assign rise_o = sync_q[0] & ~prev_q;
            assign fall_o = ~sync_q[0] & prev_q;
        end else begin : g_delay_only
            assign rise_o = 1'b0;
            assign fall_o = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/hub75_panel_rx.sv
// rtl/hub75_panel_rx.sv - HUB75 panel-side receiver with row capture dump
module hub75_panel_rx
    import hub75_pkg::*;
#(
    parameter int NUM_PANELS = 1,
    parameter int COLS       = cols_for(NUM_PANELS),
    parameter int ROW_BITS   = DEF_ROW_BITS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sclk_in,
    input  logic                    lat_in,
    input  logic                    blank_in,
    input  logic [ROW_BITS-1:0]     row_in,
    input  logic [2:0]              rgb1_in,
    input  logic [2:0]              rgb2_in,
    input  logic                    pix_ready,
    output logic                    pix_wr,
    output logic [ROW_BITS-1:0]     pix_row,
    output logic [$clog2(COLS)-1:0] pix_col,
    output logic [5:0]              pix_data,
    output logic                    row_done,
    output logic                    row_valid,
    output logic [ROW_BITS-1:0]     displayed_row,
    output logic                    err_short,
    output logic                    err_long,
    output logic                    err_overrun,
    input  logic                    err_clr
);

    localparam int COL_W = $clog2(COLS);
    localparam int CNT_W = $clog2(COLS + 2);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(COLS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(COLS);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

    logic                   sclk_s, lat_s, blank_s;
    logic                   sclk_rise, sclk_fall, lat_rise, lat_fall;
    logic                   blank_rise, blank_fall;
    logic [ROW_BITS+5:0]    data_s;
    logic                   data_rise, data_fall;
    logic [ROW_BITS-1:0]    row_s;
    pix_t                   pix_s;
    logic                   unused_sync;

    hub75_in_sync #(.WIDTH(1), .RST_VAL(1'b0), .EDGES(1'b1)) u_sync_sclk (
        .clk(clk), .rst(rst), .d_i(sclk_in),
        .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    hub75_in_sync #(.WIDTH(1), .RST_VAL(1'b0), .EDGES(1'b1)) u_sync_lat (
        .clk(clk), .rst(rst), .d_i(lat_in),
        .q_o(lat_s), .rise_o(lat_rise), .fall_o(lat_fall)
    );

    hub75_in_sync #(.WIDTH(1), .RST_VAL(1'b1), .EDGES(1'b1)) u_sync_blank (
        .clk(clk), .rst(rst), .d_i(blank_in),
        .q_o(blank_s), .rise_o(blank_rise), .fall_o(blank_fall)
    );

    // Data bus only needs the same two-cycle delay to stay aligned with the controls
    hub75_in_sync #(.WIDTH(ROW_BITS + 6), .RST_VAL('0), .EDGES(1'b0)) u_delay_data (
        .clk(clk), .rst(rst), .d_i({row_in, rgb2_in, rgb1_in}),
        .q_o(data_s), .rise_o(data_rise), .fall_o(data_fall)
    );

    assign row_s       = data_s[ROW_BITS+5:6];
    assign pix_s       = data_s[5:0];
    assign unused_sync = ^{sclk_s, lat_s, blank_s, sclk_fall, lat_fall, data_rise, data_fall};

    state_e                 state_q, state_d;
    logic [COL_W-1:0]       col_q, col_d;
    logic [COL_W-1:0]       col_rev;
    pix_t [COLS-1:0]        sr_q, sr_d;
    pix_t [COLS-1:0]        hold_q, hold_d;
    logic [ROW_BITS-1:0]    hold_row_q, hold_row_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   err_short_q, err_short_d;
    logic                   err_long_q, err_long_d;
    logic                   err_overrun_q, err_overrun_d;
    logic                   row_valid_q, row_valid_d;
    logic [ROW_BITS-1:0]    disp_row_q, disp_row_d;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            col_q         <= '0;
            sr_q          <= '0;
            hold_q        <= '0;
            hold_row_q    <= '0;
            cnt_q         <= '0;
            err_short_q   <= 1'b0;
            err_long_q    <= 1'b0;
            err_overrun_q <= 1'b0;
            row_valid_q   <= 1'b0;
            disp_row_q    <= '0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            sr_q          <= sr_d;
            hold_q        <= hold_d;
            hold_row_q    <= hold_row_d;
            cnt_q         <= cnt_d;
            err_short_q   <= err_short_d;
            err_long_q    <= err_long_d;
            err_overrun_q <= err_overrun_d;
            row_valid_q   <= row_valid_d;
            disp_row_q    <= disp_row_d;
        end
    end

    assign col_rev = COL_LAST - col_q;

    // Shift/latch datapath, dump FSM, display tracking and outputs
    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        sr_d          = sr_q;
        hold_d        = hold_q;
        hold_row_d    = hold_row_q;
        cnt_d         = cnt_q;
        err_short_d   = err_short_q & ~err_clr;
        err_long_d    = err_long_q & ~err_clr;
        err_overrun_d = err_overrun_q & ~err_clr;
        row_valid_d   = row_valid_q;
        disp_row_d    = disp_row_q;
        pix_wr        = 1'b0;
        pix_row       = '0;
        pix_col       = '0;
        pix_data      = '0;
        row_done      = 1'b0;

        if (sclk_rise) begin
            sr_d = {sr_q[COLS-2:0], pix_s};
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // A coincident shift is already folded into sr_d/cnt_d here
        if (lat_rise) begin
            if (cnt_d < CNT_FULL) begin
                err_short_d = 1'b1;
            end
            if (cnt_d > CNT_FULL) begin
                err_long_d = 1'b1;
            end
            cnt_d = '0;
            if (state_q == ST_DUMP) begin
                err_overrun_d = 1'b1;
            end else begin
                hold_d     = sr_d;
                hold_row_d = row_s;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (lat_rise) begin
                    state_d = ST_DUMP;
                    col_d   = '0;
                end
            end
            ST_DUMP: begin
                pix_wr   = 1'b1;
                pix_row  = hold_row_q;
                pix_col  = col_q;
                pix_data = hold_q[col_rev];
                if (pix_ready) begin
                    if (col_q == COL_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                row_done = 1'b1;
                if (lat_rise) begin
                    state_d = ST_DUMP;
                    col_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (blank_fall) begin
            row_valid_d = 1'b1;
            disp_row_d  = hold_row_q;
        end else if (blank_rise) begin
            row_valid_d = 1'b0;
        end
    end

    assign row_valid     = row_valid_q;
    assign displayed_row = disp_row_q;
    assign err_short     = err_short_q;
    assign err_long      = err_long_q;
    assign err_overrun   = err_overrun_q;

endmodule

// File: tb/tb_hub75_panel_rx.sv
// tb/tb_hub75_panel_rx.sv - scoreboard bench for hub75_panel_rx
module tb_hub75_panel_rx;

    localparam int COLS = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk_in = 1'b0;
    logic       lat_in = 1'b0;
    logic       blank_in = 1'b1;
    logic [2:0] row_in = '0;
    logic [2:0] rgb1_in = '0;
    logic [2:0] rgb2_in = '0;
    logic       pix_ready = 1'b1;
    logic       err_clr = 1'b0;
    logic       pix_wr;
    logic [2:0] pix_row;
    logic [4:0] pix_col;
    logic [5:0] pix_data;
    logic       row_done;
    logic       row_valid;
    logic [2:0] displayed_row;
    logic       err_short;
    logic       err_long;
    logic       err_overrun;

    hub75_panel_rx dut (
        .clk(clk), .rst(rst),
        .sclk_in(sclk_in), .lat_in(lat_in), .blank_in(blank_in),
        .row_in(row_in), .rgb1_in(rgb1_in), .rgb2_in(rgb2_in),
        .pix_ready(pix_ready), .pix_wr(pix_wr), .pix_row(pix_row),
        .pix_col(pix_col), .pix_data(pix_data), .row_done(row_done),
        .row_valid(row_valid), .displayed_row(displayed_row),
        .err_short(err_short), .err_long(err_long), .err_overrun(err_overrun),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int row;
        int col;
        int data;
    } exp_t;

    exp_t exp_q[$];
    int   hist[$];
    int   tests = 0;
    int   errors = 0;
    bit   done_pending = 1'b0;
    int   wr_cycles = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hist_reset();
        hist.delete();
        for (int i = 0; i < COLS; i++) hist.push_back(0);
    endtask

    function automatic int exp_at(input int c);
        return hist[hist.size() - COLS + c];
    endfunction

    task automatic shift_word(input int d);
        rgb1_in = d[2:0];
        rgb2_in = d[5:3];
        sclk_in = 1'b1;
        step(4);
        sclk_in = 1'b0;
        step(4);
        hist.push_back(d & 63);
    endtask

    task automatic latch(input int row);
        row_in = row[2:0];
        lat_in = 1'b1;
        step(4);
        lat_in = 1'b0;
        step(4);
    endtask

    task automatic expect_row(input int row);
        exp_t e;
        for (int c = 0; c < COLS; c++) begin
            e.row = row;
            e.col = c;
            e.data = exp_at(c);
            exp_q.push_back(e);
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0 && !pix_wr && !done_pending) break;
            step(1);
        end
        check(name, exp_q.size(), 0);
        step(2);
    endtask

    task automatic wait_col(input string name, input int target);
        for (int i = 0; i < 300; i++) begin
            if (pix_wr && int'(pix_col) >= target) break;
            step(1);
        end
        check(name, int'(pix_wr && int'(pix_col) == target), 1);
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        step(1);
    endtask

    // Monitor: pops one expectation per accepted write, checks the row_done pulse
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (done_pending) begin
                check("row_done_pulse", int'(row_done), 1);
                done_pending = 1'b0;
            end else if (row_done) begin
                check("row_done_spurious", int'(row_done), 0);
            end
            if (pix_wr) wr_cycles++;
            if (pix_wr && pix_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write_col", int'(pix_col), -1);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_row", int'(pix_row), e.row);
                    check("wr_col", int'(pix_col), e.col);
                    check("wr_data", int'(pix_data), e.data);
                    if (e.col == COLS - 1) done_pending = 1'b1;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        hist_reset();
        step(3);
        check("rst_pix_wr", int'(pix_wr), 0);
        check("rst_pix_col", int'(pix_col), 0);
        check("rst_row_done", int'(row_done), 0);
        check("rst_row_valid", int'(row_valid), 0);
        check("rst_errs", int'({err_short, err_long, err_overrun}), 0);
        rst = 1'b0;
        step(4);

        // 1: full row, data = column index
        for (int c = 0; c < COLS; c++) shift_word(c);
        expect_row(5);
        wr_cycles = 0;
        latch(5);
        drain("t1_drain");
        check("t1_wr_cycles", wr_cycles, COLS);
        check("t1_errs", int'({err_short, err_long, err_overrun}), 0);

        // 2: backpressure at column 10
        for (int c = 0; c < COLS; c++) shift_word(c | 32);
        expect_row(1);
        latch(1);
        wait_col("t2_reach_col9", 9);
        step(1);
        pix_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t2_stall_col", int'(pix_col), 10);
            check("t2_stall_data", int'(pix_data), exp_at(10));
            step(1);
        end
        pix_ready = 1'b1;
        @(negedge clk);
        check("t2_stall_col_last", int'(pix_col), 10);
        step(1);
        drain("t2_drain");

        // 3: short row then long row, then clear
        for (int c = 0; c < 20; c++) shift_word((c * 3) & 63);
        expect_row(2);
        latch(2);
        check("t3_err_short", int'(err_short), 1);
        check("t3_err_long_clear", int'(err_long), 0);
        drain("t3_short_drain");
        for (int c = 0; c < 40; c++) shift_word((c + 7) & 63);
        expect_row(3);
        latch(3);
        check("t3_err_long", int'(err_long), 1);
        drain("t3_long_drain");
        clear_errs();
        check("t3_cleared", int'({err_short, err_long, err_overrun}), 0);

        // 4: overrun latch mid-dump is dropped
        for (int c = 0; c < COLS; c++) shift_word(c ^ 6'h2a);
        expect_row(2);
        latch(2);
        wait_col("t4_reach_col12", 12);
        latch(6);
        check("t4_err_overrun", int'(err_overrun), 1);
        check("t4_err_short_zero_shifts", int'(err_short), 1);
        drain("t4_drain");
        clear_errs();

        // 5: display tracking
        for (int c = 0; c < COLS; c++) shift_word(63 - c);
        expect_row(3);
        latch(3);
        drain("t5_drain");
        check("t5_row_valid_before", int'(row_valid), 0);
        blank_in = 1'b0;
        step(3);
        check("t5_row_valid", int'(row_valid), 1);
        check("t5_displayed_row", int'(displayed_row), 3);
        blank_in = 1'b1;
        step(3);
        check("t5_row_valid_off", int'(row_valid), 0);

        // 6: reset mid-dump, then a clean row
        for (int c = 0; c < COLS; c++) shift_word(c);
        expect_row(4);
        latch(4);
        wait_col("t6_reach_col15", 15);
        rst = 1'b1;
        exp_q.delete();
        done_pending = 1'b0;
        #1;
        check("t6_pix_wr_async", int'(pix_wr), 0);
        step(3);
        rst = 1'b0;
        hist_reset();
        step(3);
        check("t6_pix_wr_idle", int'(pix_wr), 0);
        check("t6_errs", int'({err_short, err_long, err_overrun}), 0);
        for (int c = 0; c < COLS; c++) shift_word((c * 5 + 1) & 63);
        expect_row(7);
        latch(7);
        drain("t6_drain");
        check("t6_errs_after", int'({err_short, err_long, err_overrun}), 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
